cla_addsub_pipe: RTL

//  Two-stage pipelined WIDTH-bit adder/subtractor on carry-lookahead groups; the arithmetic datapath that consumes group P/G/carry.

---
 rtl/cla_pkg.sv | 11 +
 rtl/cla_group_pg.sv | 41 ++++
 rtl/cla_addsub_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int cla_ngroup(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// One lookahead group: group propagate/generate from bit p/g, and every bit carry
// inside the group computed directly from the group carry-in (no intra-group ripple).
module cla_group_pg #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic             gp,
  output logic             gg,
  output logic [GROUP-1:0] c
);

  logic term;
  logic acc;

  always_comb begin
    gp   = &p;
    gg   = 1'b0;
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int k = j + 1; k < GROUP; k++) term = term & p[k];
      gg = gg | term;
    end
    // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin, each as a flat product term
    for (int i = 0; i < GROUP; i++) begin
      acc = cin;
      for (int k = 0; k < i; k++) acc = acc & p[k];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined add/subtract: stage 1 registers bit and group P/G, stage 2 resolves
// group carries by full lookahead and registers sum and flags.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NGROUP = cla_ngroup(WIDTH, GROUP);

  if (WIDTH % GROUP != 0) begin : g_width_chk
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP");
  end

  logic [WIDTH-1:0]  bx, p_in, g_in, s1_c_unused;
  logic              c0_in;
  logic [NGROUP-1:0] gp_in, gg_in, s2_gp_unused, s2_gg_unused;

  logic              s1_valid, s1_c0, s1_op;
  logic [WIDTH-1:0]  s1_p, s1_g;
  logic [NGROUP-1:0] s1_gp, s1_gg;

  logic [NGROUP:0]   gc;
  logic [WIDTH-1:0]  bc, sum;
  logic              carry_out, ovf, term, acc;
  logic              s1_en, s2_en;

  // Handshake: a beat moves on a side when valid & ready are both high at the rising edge;
  // in_ready depends combinationally on out_ready, so a full pipe drains and refills in one cycle.
  assign s2_en    = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_en;
  assign s1_en    = in_valid & in_ready;

  // Subtract is a + ~b + ~borrow_in.
  assign bx    = (in_op == OP_ADD) ? in_b : ~in_b;
  assign c0_in = (in_op == OP_SUB) ? ~in_cin : in_cin;
  assign p_in  = in_a ^ bx;
  assign g_in  = in_a & bx;

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_grp
    cla_group_pg #(.GROUP(GROUP)) u_pg1 (
      .p  (p_in[gi*GROUP +: GROUP]),
      .g  (g_in[gi*GROUP +: GROUP]),
      .cin(1'b0),
      .gp (gp_in[gi]),
      .gg (gg_in[gi]),
      .c  (s1_c_unused[gi*GROUP +: GROUP])
    );
    cla_group_pg #(.GROUP(GROUP)) u_pg2 (
      .p  (s1_p[gi*GROUP +: GROUP]),
      .g  (s1_g[gi*GROUP +: GROUP]),
      .cin(gc[gi]),
      .gp (s2_gp_unused[gi]),
      .gg (s2_gg_unused[gi]),
      .c  (bc[gi*GROUP +: GROUP])
    );
  end

  // Group carries as flat sum-of-products over registered GP/GG and c0.
  always_comb begin
    gc    = '0;
    gc[0] = s1_c0;
    term  = 1'b0;
    acc   = 1'b0;
    for (int k = 0; k < NGROUP; k++) begin
      acc = s1_c0;
      for (int j = 0; j <= k; j++) acc = acc & s1_gp[j];
      for (int j = 0; j <= k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m <= k; m++) term = term & s1_gp[m];
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  assign sum       = s1_p ^ bc;
  assign carry_out = gc[NGROUP];
  assign ovf       = bc[WIDTH-1] ^ carry_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_c0    <= 1'b0;
      s1_op    <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_en) begin
      s1_valid <= 1'b1;
      s1_p     <= p_in;
      s1_g     <= g_in;
      s1_c0    <= c0_in;
      s1_op    <= in_op;
      s1_gp    <= gp_in;
      s1_gg    <= gg_in;
    end else if (s2_en) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_cout  <= carry_out ^ s1_op;
      out_ovf   <= ovf;
      out_zero  <= ~|sum;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
